// File: rtl/nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_pkg : shared widths, FSM states and saturation helper              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package nn_pkg;

  localparam int N_HID    = 8;
  localparam int ACT_W    = 10;
  localparam int PRED_W   = 23;
  localparam int ERR_W    = 12;
  localparam int WEIGHT_W = 8;
  localparam int LR_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    UPDATE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Clamp x into the signed range of a 'width'-bit two's complement value.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi)      sat_signed = hi;
    else if (x < lo) sat_signed = lo;
    else             sat_signed = x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_weight_updater_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_delta_alu : w_next = sat(w - ((err * h) >>> LR_SHIFT))         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module weight_delta_alu
  import nn_pkg::*;
(
  input  logic signed [ERR_W-1:0]    err,
  input  logic        [ACT_W-1:0]    h,
  input  logic signed [WEIGHT_W-1:0] w,
  output logic signed [WEIGHT_W-1:0] w_next,
  output logic                       sat
);

  localparam int PROD_W = ERR_W + ACT_W + 1;

  logic signed [PROD_W-1:0] err_x;
  logic signed [PROD_W-1:0] h_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] delta;
  logic signed [PROD_W:0]   diff;
  logic signed [63:0]       diff_x;

  assign err_x  = PROD_W'(err);
  assign h_x    = $signed(PROD_W'(h));
  assign prod   = err_x * h_x;
  // Arithmetic shift floors toward -inf, so small negative products still move w.
  assign delta  = prod >>> LR_SHIFT;
  assign diff   = (PROD_W+1)'(w) - (PROD_W+1)'(delta);
  assign diff_x = 64'(diff);

  assign w_next = WEIGHT_W'(sat_signed(diff_x, WEIGHT_W));
  assign sat    = (sat_signed(diff_x, WEIGHT_W) != diff_x);

endmodule
`default_nettype wire

// File: rtl/output_weight_updater.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_weight_updater : serial gradient update of hidden->out weights |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module output_weight_updater
  import nn_pkg::*;
#(
  parameter logic [N_HID*WEIGHT_W-1:0] W_INIT = 64'h0807060504030201
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      start_i,
  input  logic [PRED_W-1:0]         pred_i,
  input  logic [PRED_W-1:0]         target_i,
  input  logic [N_HID*ACT_W-1:0]    h_i,
  output logic [N_HID*WEIGHT_W-1:0] weights_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      sat_o
);

  localparam int IDX_W = $clog2(N_HID);

  state_t                    state;
  state_t                    state_nx;
  logic [IDX_W-1:0]          idx;
  logic signed [ERR_W-1:0]   err;
  logic [N_HID*ACT_W-1:0]    h_lat;
  logic [N_HID*WEIGHT_W-1:0] weights;
  logic                      sat;

  logic signed [PRED_W:0]    err_raw;
  logic signed [63:0]        err_raw_x;
  logic                      err_sat;
  logic signed [WEIGHT_W-1:0] alu_w_next;
  logic                      alu_sat;
  logic                      last_idx;

  assign err_raw   = $signed({1'b0, pred_i}) - $signed({1'b0, target_i});
  assign err_raw_x = 64'(err_raw);
  assign err_sat   = (sat_signed(err_raw_x, ERR_W) != err_raw_x);
  assign last_idx  = (idx == IDX_W'(N_HID - 1));

  weight_delta_alu u_alu (
    .err    (err),
    .h      (h_lat[idx*ACT_W +: ACT_W]),
    .w      (weights[idx*WEIGHT_W +: WEIGHT_W]),
    .w_next (alu_w_next),
    .sat    (alu_sat)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (en_i) begin
      case (state)
        IDLE:    if (start_i) state_nx = CAPTURE;
        CAPTURE: state_nx = UPDATE;
        UPDATE:  if (last_idx) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      weights <= W_INIT;
      idx     <= '0;
      err     <= '0;
      h_lat   <= '0;
      sat     <= 1'b0;
    end else if (en_i) begin
      case (state)
        IDLE: begin
          if (start_i) sat <= 1'b0;
        end
        CAPTURE: begin
          h_lat <= h_i;
          err   <= ERR_W'(sat_signed(err_raw_x, ERR_W));
          idx   <= '0;
          if (err_sat) sat <= 1'b1;
        end
        UPDATE: begin
          weights[idx*WEIGHT_W +: WEIGHT_W] <= alu_w_next;
          idx <= last_idx ? '0 : idx + IDX_W'(1);
          if (alu_sat) sat <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign weights_o = weights;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign sat_o     = sat;

endmodule
`default_nettype wire

// File: tb/tb_output_weight_updater.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_output_weight_updater : directed self-checking bench               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_output_weight_updater;

  localparam logic [63:0] W_INIT_C = 64'h0807060504030201;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        start_i;
  logic [22:0] pred_i;
  logic [22:0] target_i;
  logic [79:0] h_i;
  logic [63:0] weights_o;
  logic        busy_o;
  logic        done_o;
  logic        sat_o;

  int checks = 0;
  int failures = 0;

  output_weight_updater dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .start_i   (start_i),
    .pred_i    (pred_i),
    .target_i  (target_i),
    .h_i       (h_i),
    .weights_o (weights_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_i = 1'b0; en_i = 1'b1; start_i = 1'b0;
    pred_i = '0; target_i = '0; h_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge just after the accepting edge.
  task automatic start_pass(input logic [22:0] p, input logic [22:0] t, input logic [79:0] h);
    pred_i = p; target_i = t; h_i = h; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_to_idle(output int done_at, output int done_cnt, output int busy_cyc);
    busy_cyc = busy_o ? 1 : 0;
    done_at  = -1;
    done_cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (busy_o) busy_cyc++;
      else break;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (weights_o !== W_INIT_C) begin failures++; $display("FAIL reset_weights: got %h expected %h", weights_o, W_INIT_C); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b expected 0", sat_o); end
  endtask

  task automatic test_basic_pass();
    int da, dc, bc;
    do_reset();
    start_pass(23'd100, 23'd90, {8{10'd16}});
    run_to_idle(da, dc, bc);
    checks++; if (weights_o !== 64'hFEFDFCFBFAF9F8F7) begin failures++; $display("FAIL basic_weights: got %h expected %h", weights_o, 64'hFEFDFCFBFAF9F8F7); end
    checks++; if (da !== 9) begin failures++; $display("FAIL basic_done_timing: got %0d expected 9", da); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_width: got %0d expected 1", dc); end
    checks++; if (bc !== 10) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 10", bc); end
    checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL basic_sat: got %b expected 0", sat_o); end
  endtask

  task automatic test_floor_rounding();
    int da, dc, bc;
    do_reset();
    start_pass(23'd90, 23'd91, {70'd0, 10'd1});
    run_to_idle(da, dc, bc);
    checks++; if (weights_o !== 64'h0807060504030202) begin failures++; $display("FAIL floor_weights: got %h expected %h", weights_o, 64'h0807060504030202); end
    checks++; if (bc !== 10) begin failures++; $display("FAIL floor_busy_cycles: got %0d expected 10", bc); end
  endtask

  task automatic test_saturation();
    int da, dc, bc;
    do_reset();
    start_pass(23'd4000, 23'd0, {8{10'd1023}});
    run_to_idle(da, dc, bc);
    checks++; if (weights_o !== 64'h8080808080808080) begin failures++; $display("FAIL sat_weights: got %h expected %h", weights_o, 64'h8080808080808080); end
    checks++; if (sat_o !== 1'b1) begin failures++; $display("FAIL sat_flag: got %b expected 1", sat_o); end
    start_pass(23'd5, 23'd5, 80'd0);
    checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL sat_clear_on_start: got %b expected 0", sat_o); end
    run_to_idle(da, dc, bc);
    checks++; if (weights_o !== 64'h8080808080808080) begin failures++; $display("FAIL zero_err_weights: got %h expected %h", weights_o, 64'h8080808080808080); end
    checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL zero_err_sat: got %b expected 0", sat_o); end
    // Negative error clamps to -2048; w0 = 1 + 128 clamps to +127.
    do_reset();
    start_pass(23'd0, 23'd4000, {70'd0, 10'd1});
    run_to_idle(da, dc, bc);
    checks++; if (weights_o !== 64'h080706050403027F) begin failures++; $display("FAIL neg_sat_weights: got %h expected %h", weights_o, 64'h080706050403027F); end
    checks++; if (sat_o !== 1'b1) begin failures++; $display("FAIL neg_sat_flag: got %b expected 1", sat_o); end
  endtask

  task automatic test_enable_and_async_reset();
    int da, dc, bc;
    do_reset();
    start_pass(23'd100, 23'd90, {8{10'd16}});
    repeat (4) @(posedge clk);
    @(negedge clk);
    en_i = 1'b0;
    checks++; if (weights_o !== 64'h0807060504F9F8F7) begin failures++; $display("FAIL freeze_entry_weights: got %h expected %h", weights_o, 64'h0807060504F9F8F7); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (weights_o !== 64'h0807060504F9F8F7) begin failures++; $display("FAIL freeze_hold_weights: got %h expected %h", weights_o, 64'h0807060504F9F8F7); end
    checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL freeze_status: got busy=%b done=%b expected busy=1 done=0", busy_o, done_o); end
    en_i = 1'b1;
    run_to_idle(da, dc, bc);
    checks++; if (da !== 5) begin failures++; $display("FAIL freeze_done_delay: got %0d expected 5", da); end
    checks++; if (weights_o !== 64'hFEFDFCFBFAF9F8F7) begin failures++; $display("FAIL freeze_final_weights: got %h expected %h", weights_o, 64'hFEFDFCFBFAF9F8F7); end
    // Second pass aborted by reset once idx reaches 5.
    @(negedge clk);
    start_pass(23'd100, 23'd90, {8{10'd16}});
    repeat (6) @(posedge clk);
    #2;
    checks++; if (weights_o === W_INIT_C) begin failures++; $display("FAIL midpass_progress: got %h expected weights changed from %h", weights_o, W_INIT_C); end
    rst_i = 1'b0;
    #1;
    checks++; if (weights_o !== W_INIT_C) begin failures++; $display("FAIL async_reset_weights: got %h expected %h", weights_o, W_INIT_C); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || sat_o !== 1'b0) begin failures++; $display("FAIL async_reset_status: got busy=%b done=%b sat=%b expected 0 0 0", busy_o, done_o, sat_o); end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    int dones = 0;
    int da, dc, bc;
    do_reset();
    pred_i = 23'd5; target_i = 23'd5; h_i = '0; start_i = 1'b1;
    for (int j = 0; j <= 32; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy_o !== ((j % 11) != 10)) errs++;
      if (done_o === 1'b1) dones++;
    end
    start_i = 1'b0;
    run_to_idle(da, dc, bc);
    checks++; if (errs !== 0) begin failures++; $display("FAIL b2b_busy_pattern: got %0d wrong cycles expected 0", errs); end
    checks++; if (dones !== 3) begin failures++; $display("FAIL b2b_done_count: got %0d expected 3", dones); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_return_idle: got busy=%b expected 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_floor_rounding();
    test_saturation();
    test_enable_and_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
